// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the bit-serial add/subtract unit and its control unit.
package serial_add_unit_pkg;

  // Default operand width, also used by the control unit.
  localparam int SAU_DEFAULT_WIDTH = 8;

  // Controller state encodings. Encoding 2'd3 is illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    SAU_IDLE  = 2'd0,
    SAU_SHIFT = 2'd1,
    SAU_DONE  = 2'd2
  } sau_state_e;

endpackage

// File: rtl/serial_add_unit_adder.sv
// ADDER: the 1-bit full-adder cell of the structural datapath.
module ADDER (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract engine: one operand bit pair per clock through a
// single full-adder cell, LSB first, with the carry held in a flop.
module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = SAU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  sau_state_e       state_r;
  sau_state_e       state_next_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             cell_sum_s;
  logic             cell_cout_s;

  // The single arithmetic cell; everything else only moves bits around.
  ADDER u_adder (
    .A     (a_sr_r[0]),
    .B     (b_sr_r[0]),
    .C_in  (carry_r),
    .S     (cell_sum_s),
    .C_out (cell_cout_s)
  );

  // Next-state logic; DONE always lasts one cycle and illegal codes recover to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SAU_IDLE: begin
        if (start) begin
          state_next_s = SAU_SHIFT;
        end else begin
          state_next_s = SAU_IDLE;
        end
      end
      SAU_SHIFT: begin
        if (count_r == LAST_COUNT) begin
          state_next_s = SAU_DONE;
        end else begin
          state_next_s = SAU_SHIFT;
        end
      end
      SAU_DONE: state_next_s = SAU_IDLE;
      default:  state_next_s = SAU_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SAU_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == SAU_SHIFT);
      done_r  <= (state_next_s == SAU_DONE);
    end
  end

  // Datapath: load operands on accept (B inverted and carry-in set for
  // subtraction), shift one bit per SHIFT cycle, latch results on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_sr_r    <= '0;
      carry_r     <= 1'b0;
      count_r     <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        SAU_IDLE: begin
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= sub ? ~b : b;
            carry_r <= sub;
            count_r <= '0;
          end
        end
        SAU_SHIFT: begin
          res_sr_r <= {cell_sum_s, res_sr_r[WIDTH-1:1]};
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r  <= cell_cout_s;
          count_r  <= count_r + CW'(1);
          if (count_r == LAST_COUNT) begin
            // carry_r here is the carry into the MSB position.
            overflow_r  <= carry_r ^ cell_cout_s;
            carry_out_r <= cell_cout_s;
            sum_r       <= {cell_sum_s, res_sr_r[WIDTH-1:1]};
          end
        end
        default: begin
          // DONE and illegal encodings leave the datapath untouched.
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit (WIDTH=8).
module tb_serial_add_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: accept at edge 0, busy after edges 0..7, done after edge 8.
  // ign_k >= 0 pulses start with other operands during the cycle after edge ign_k.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                        input logic [7:0] exp_sum, input logic exp_co, input logic exp_ov,
                        input int ign_k);
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A; sub = ~vs;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("busy_in_shift", {31'd0, busy}, 32'd1);
      chk("done_in_shift", {31'd0, done}, 32'd0);
      if (k == ign_k) begin
        start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("sum", {24'd0, sum}, {24'd0, exp_sum});
    chk("carry_out", {31'd0, carry_out}, {31'd0, exp_co});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ov});
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("sum_held", {24'd0, sum}, {24'd0, exp_sum});
  endtask

  initial begin
    logic saw_done;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_co", {31'd0, carry_out}, 32'd0);
    chk("rst_ov", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Additions.
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);

    // Subtractions.
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1);

    // start during SHIFT cycle 3 is ignored.
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 3);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      saw_done = saw_done | done | busy;
    end
    chk("no_second_op", {31'd0, saw_done}, 32'd0);

    // Reset during SHIFT cycle 4 aborts the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, -1);

    // start held high: done every 10 cycles, sum stable.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("held_done", {31'd0, done}, {31'd0, ((k % 10) == 8)});
      if (k >= 8) begin
        chk("held_sum", {24'd0, sum}, 32'h7F);
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
